// File: rtl/spi_master_multi.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : spi_master_multi
// Brief    : N-lane SPI master (CPOL=0, CPHA=0) with shared CS/SCLK,
//            programmable SCLK divider, CS-off time, MISO sample-delay
//            compensation and a wrapping transfer counter.
// Revision : 1.0 - initial release
// ============================================================================
module spi_master_multi #(
    parameter int WORD_LENGTH    = 32,
    parameter int N_CH           = 4,
    parameter int HALF_PERIOD    = 2,
    parameter int CS_HIGH_CYCLES = 16,
    parameter int MISO_DELAY     = 0,
    parameter int COUNT_WIDTH    = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    output logic                          cs,
    output logic                          sclk,
    output logic [N_CH-1:0]               mosi,
    input  logic [N_CH-1:0]               miso,
    input  logic                          data_in_v,
    output logic                          ready_out,
    input  logic [N_CH*WORD_LENGTH-1:0]   data_in,
    output logic                          data_out_v,
    output logic [N_CH*WORD_LENGTH-1:0]   data_out,
    output logic [COUNT_WIDTH-1:0]        xfer_count
);

    localparam int DW    = N_CH * WORD_LENGTH;
    localparam int PH_W  = $clog2(2 * HALF_PERIOD + 1);
    localparam int BIT_W = $clog2(WORD_LENGTH);
    localparam int OFF_W = $clog2(CS_HIGH_CYCLES + 1);

    localparam logic [PH_W-1:0]  PH_HALF_LAST = PH_W'(HALF_PERIOD - 1);
    localparam logic [PH_W-1:0]  PH_BIT_LAST  = PH_W'(2 * HALF_PERIOD - 1);
    localparam logic [BIT_W-1:0] BIT_LAST     = BIT_W'(WORD_LENGTH - 1);
    localparam logic [OFF_W-1:0] OFF_LAST     = OFF_W'(CS_HIGH_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        SHIFT  = 2'd2,
        CS_OFF = 2'd3
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [PH_W-1:0]   phase;
    logic [PH_W-1:0]   phase_next;
    logic [BIT_W-1:0]  bit_idx;
    logic [OFF_W-1:0]  off_cnt;
    logic              handshake;
    logic              fall_edge;
    logic              bit_end;
    logic              xfer_done;
    logic              sclk_next;
    logic              arm;
    logic              sample;
    logic [DW-1:0]     tx_sr;
    logic [DW-1:0]     tx_shifted;
    logic [DW-1:0]     rx_sr;
    logic [DW-1:0]     rx_next;

    // Next-state, phase counter and per-cycle event decode
    always_comb begin
        state_next = state;
        phase_next = '0;
        handshake  = 1'b0;
        fall_edge  = 1'b0;
        bit_end    = 1'b0;
        xfer_done  = 1'b0;
        case (state)
            IDLE: begin
                if (data_in_v) begin
                    handshake  = 1'b1;
                    state_next = SETUP;
                end
            end
            SETUP: begin
                if (phase == PH_HALF_LAST) begin
                    state_next = SHIFT;
                end else begin
                    phase_next = phase + 1'b1;
                end
            end
            SHIFT: begin
                fall_edge = (phase == PH_HALF_LAST);
                if (phase == PH_BIT_LAST) begin
                    bit_end = 1'b1;
                    if (bit_idx == BIT_LAST) begin
                        xfer_done  = 1'b1;
                        state_next = CS_OFF;
                    end
                end else begin
                    phase_next = phase + 1'b1;
                end
            end
            CS_OFF: begin
                if (off_cnt == OFF_LAST) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
        // SCLK is high for the first half of every bit slot
        sclk_next = (state_next == SHIFT) && (phase_next <= PH_HALF_LAST);
        // A rising SCLK edge is visible in the first cycle of each bit slot
        arm = (state == SHIFT) && (phase == '0);
    end

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            phase <= '0;
        end else begin
            state <= state_next;
            phase <= phase_next;
        end
    end

    // Bit / CS-off counters and registered pin-level controls
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bit_idx   <= '0;
            off_cnt   <= '0;
            cs        <= 1'b1;
            sclk      <= 1'b0;
            ready_out <= 1'b1;
        end else begin
            if (handshake) begin
                bit_idx <= '0;
            end else if (bit_end && !xfer_done) begin
                bit_idx <= bit_idx + 1'b1;
            end
            off_cnt   <= (state == CS_OFF) ? off_cnt + 1'b1 : '0;
            cs        <= !((state_next == SETUP) || (state_next == SHIFT));
            sclk      <= sclk_next;
            ready_out <= (state_next == IDLE);
        end
    end

    // Sample strobe: the rising-edge event delayed by the round-trip compensation
    generate
        if (MISO_DELAY == 0) begin : g_no_delay
            assign sample = arm;
        end else begin : g_delay
            logic [MISO_DELAY-1:0] dly;
            // Delay line carrying one pulse per rising SCLK edge
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    dly <= '0;
                end else begin
                    dly <= (dly << 1) | MISO_DELAY'(arm);
                end
            end
            assign sample = dly[MISO_DELAY-1];
        end
    endgenerate

    // Per-lane MOSI tap, TX shift and RX shift-in
    generate
        for (genvar k = 0; k < N_CH; k++) begin : g_lane
            assign mosi[k] = tx_sr[k*WORD_LENGTH + WORD_LENGTH - 1];
            assign tx_shifted[k*WORD_LENGTH +: WORD_LENGTH] =
                {tx_sr[k*WORD_LENGTH +: WORD_LENGTH-1], 1'b0};
            assign rx_next[k*WORD_LENGTH +: WORD_LENGTH] = sample ?
                {rx_sr[k*WORD_LENGTH +: WORD_LENGTH-1], miso[k]} :
                rx_sr[k*WORD_LENGTH +: WORD_LENGTH];
        end
    endgenerate

    // TX/RX shift registers; MOSI advances on every falling edge but the last
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tx_sr <= '0;
            rx_sr <= '0;
        end else begin
            if (handshake) begin
                tx_sr <= data_in;
            end else if (fall_edge && (bit_idx != BIT_LAST)) begin
                tx_sr <= tx_shifted;
            end
            rx_sr <= rx_next;
        end
    end

    // Result publication; rx_next is used so a sample in the final cycle is kept
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            data_out_v <= 1'b0;
            data_out   <= '0;
            xfer_count <= '0;
        end else begin
            data_out_v <= xfer_done;
            if (xfer_done) begin
                data_out   <= rx_next;
                xfer_count <= xfer_count + 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_spi_master_multi.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_spi_master_multi
// Brief    : Self-checking bench for spi_master_multi: loopback, delayed
//            MISO, back-to-back, busy requests, async reset, counter wrap.
// Revision : 1.0 - initial release
// ============================================================================
module tb_spi_master_multi;

    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- DUT A: defaults, loopback or 3-cycle delayed MISO ----
    logic         a_cs, a_sclk, a_v, a_rdy, a_dv, a_dly_sel;
    logic [3:0]   a_mosi, a_miso;
    logic [3:0]   a_d1 = '0, a_d2 = '0, a_d3 = '0;
    logic [127:0] a_din, a_dout;
    logic [15:0]  a_cnt;

    always @(posedge clk) begin
        a_d1 <= a_mosi;
        a_d2 <= a_d1;
        a_d3 <= a_d2;
    end
    assign a_miso = a_dly_sel ? a_d3 : a_mosi;

    spi_master_multi dut_a (
        .clk(clk), .reset(rst_n), .cs(a_cs), .sclk(a_sclk), .mosi(a_mosi),
        .miso(a_miso), .data_in_v(a_v), .ready_out(a_rdy), .data_in(a_din),
        .data_out_v(a_dv), .data_out(a_dout), .xfer_count(a_cnt)
    );

    // ---------------- DUT B: MISO_DELAY=3 against a 3-cycle round trip ----
    logic         b_cs, b_sclk, b_v, b_rdy, b_dv;
    logic [1:0]   b_mosi;
    logic [1:0]   b_d1 = '0, b_d2 = '0, b_d3 = '0;
    logic [63:0]  b_din, b_dout;
    logic [15:0]  b_cnt;

    always @(posedge clk) begin
        b_d1 <= b_mosi;
        b_d2 <= b_d1;
        b_d3 <= b_d2;
    end

    spi_master_multi #(.N_CH(2), .MISO_DELAY(3)) dut_b (
        .clk(clk), .reset(rst_n), .cs(b_cs), .sclk(b_sclk), .mosi(b_mosi),
        .miso(b_d3), .data_in_v(b_v), .ready_out(b_rdy), .data_in(b_din),
        .data_out_v(b_dv), .data_out(b_dout), .xfer_count(b_cnt)
    );

    // ---------------- DUT C: W=16, one lane, H=1, 4-bit counter ------------
    logic         c_cs, c_sclk, c_v, c_rdy, c_dv;
    logic [0:0]   c_mosi;
    logic [15:0]  c_din, c_dout;
    logic [3:0]   c_cnt;

    spi_master_multi #(.WORD_LENGTH(16), .N_CH(1), .HALF_PERIOD(1), .COUNT_WIDTH(4)) dut_c (
        .clk(clk), .reset(rst_n), .cs(c_cs), .sclk(c_sclk), .mosi(c_mosi),
        .miso(c_mosi), .data_in_v(c_v), .ready_out(c_rdy), .data_in(c_din),
        .data_out_v(c_dv), .data_out(c_dout), .xfer_count(c_cnt)
    );

    // ---------------- Observation of DUT A --------------------------------
    int           a_cs_low = 0, a_rises = 0, a_dv_cnt = 0, a_sclk_cs_hi = 0;
    int           a_hs_q[$], a_csr_q[$], a_dvc_q[$];
    logic [127:0] a_dv_q[$];
    logic         a_prev_sclk = 1'b0, a_prev_cs = 1'b1;

    always @(negedge clk) begin
        if (a_v && a_rdy) begin
            a_hs_q.push_back(cyc);
            a_cs_low = 0;
            a_rises  = 0;
        end
        if (!a_cs) a_cs_low++;
        if (a_sclk && !a_prev_sclk) a_rises++;
        if (a_sclk && a_cs) a_sclk_cs_hi++;
        if (a_cs && !a_prev_cs) a_csr_q.push_back(cyc);
        if (a_dv) begin
            a_dv_cnt++;
            a_dv_q.push_back(a_dout);
            a_dvc_q.push_back(cyc);
        end
        a_prev_sclk = a_sclk;
        a_prev_cs   = a_cs;
    end

    // ---------------- Observation of DUT B and C --------------------------
    int           b_dv_cnt = 0;
    logic [63:0]  b_dv_q[$];
    int           c_dv_cnt = 0, c_cs_low = 0, c_rin = 0, c_last = 0, c_bad = 0;
    logic [15:0]  c_dv_q[$];
    logic         c_prev_sclk = 1'b0;

    always @(negedge clk) begin
        if (b_dv) begin
            b_dv_cnt++;
            b_dv_q.push_back(b_dout);
        end
        if (c_v && c_rdy) begin
            c_cs_low = 0;
            c_rin    = 0;
        end
        if (!c_cs) c_cs_low++;
        if (c_sclk && !c_prev_sclk) begin
            if (c_rin > 0 && (cyc - c_last) != 2) c_bad++;
            c_last = cyc;
            c_rin++;
        end
        if (c_dv) begin
            c_dv_cnt++;
            c_dv_q.push_back(c_dout);
        end
        c_prev_sclk = c_sclk;
    end

    // ---------------- Checking --------------------------------------------
    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic a_clear();
        a_hs_q.delete();
        a_csr_q.delete();
        a_dvc_q.delete();
        a_dv_q.delete();
        a_dv_cnt = 0;
    endtask

    task automatic a_send(input logic [127:0] din);
        int n = 0;
        @(posedge clk); #1;
        while (!a_rdy && n < 400) begin
            @(posedge clk); #1;
            n++;
        end
        if (!a_rdy) check("a_ready_timeout", 128'(a_rdy), 128'd1);
        a_din = din;
        a_v   = 1'b1;
        @(posedge clk); #1;
        a_v   = 1'b0;
    endtask

    task automatic a_wait_dv(input int target);
        int n = 0;
        while (a_dv_cnt < target && n < 1000) begin
            @(posedge clk);
            n++;
        end
        if (a_dv_cnt < target) check("a_dv_timeout", 128'(a_dv_cnt), 128'(target));
    endtask

    task automatic b_xfer(input logic [63:0] din);
        int n = 0;
        int start = b_dv_cnt;
        @(posedge clk); #1;
        while (!b_rdy && n < 400) begin
            @(posedge clk); #1;
            n++;
        end
        b_din = din;
        b_v   = 1'b1;
        @(posedge clk); #1;
        b_v   = 1'b0;
        n = 0;
        while (b_dv_cnt == start && n < 400) begin
            @(posedge clk);
            n++;
        end
        check("b_delay_comp_data", 128'((b_dv_q.size() > 0) ? b_dv_q[$] : 64'hx), 128'(din));
    endtask

    task automatic c_xfer(input logic [15:0] din, input int target);
        int n = 0;
        @(posedge clk); #1;
        while (!c_rdy && n < 400) begin
            @(posedge clk); #1;
            n++;
        end
        c_din = din;
        c_v   = 1'b1;
        @(posedge clk); #1;
        c_v   = 1'b0;
        n = 0;
        while (c_dv_cnt < target && n < 400) begin
            @(posedge clk);
            n++;
        end
        if (c_dv_cnt < target) check("c_dv_timeout", 128'(c_dv_cnt), 128'(target));
    endtask

    // ---------------- Stimulus --------------------------------------------
    initial begin
        logic [127:0] din;
        logic [127:0] w [3];
        logic [15:0]  cd;
        int           n;

        rst_n = 1'b0;
        a_v = 1'b0; b_v = 1'b0; c_v = 1'b0;
        a_din = '0; b_din = '0; c_din = '0;
        a_dly_sel = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_cs",    128'(a_cs),   128'd1);
        check("reset_sclk",  128'(a_sclk), 128'd0);
        check("reset_mosi",  128'(a_mosi), 128'd0);
        check("reset_dv",    128'(a_dv),   128'd0);
        check("reset_dout",  a_dout,       128'd0);
        check("reset_count", 128'(a_cnt),  128'd0);
        check("reset_ready", 128'(a_rdy),  128'd1);
        @(negedge clk);
        rst_n = 1'b1;

        // Single transfer, loopback, fixed pattern
        a_clear();
        din = {32'h00000000, 32'hFFFFFFFF, 32'h80000000, 32'hA5A50001};
        a_send(din);
        a_wait_dv(1);
        repeat (5) @(posedge clk);
        check("t1_data",     (a_dv_q.size() > 0) ? a_dv_q[0] : 128'hx, din);
        check("t1_cs_low",   128'(a_cs_low), 128'd130);
        check("t1_rises",    128'(a_rises),  128'd32);
        check("t1_dv_lat",   128'((a_dvc_q.size() > 0 && a_hs_q.size() > 0) ? a_dvc_q[0] - a_hs_q[0] : -1), 128'd131);
        check("t1_count",    128'(a_cnt),    128'd1);
        check("t1_dv_pulse", 128'(a_dv_cnt), 128'd1);

        // Randomized loopback
        for (int t = 0; t < 3; t++) begin
            a_clear();
            din = rand128();
            a_send(din);
            a_wait_dv(1);
            check("rand_loopback", (a_dv_q.size() > 0) ? a_dv_q[0] : 128'hx, din);
        end

        // Delayed MISO without compensation: every lane arrives one bit late
        a_dly_sel = 1'b1;
        for (int t = 0; t < 2; t++) begin
            a_clear();
            din = rand128();
            a_send(din);
            a_wait_dv(1);
            for (int k = 0; k < 4; k++)
                check("late_lane", 128'((a_dv_q.size() > 0) ? a_dv_q[0][k*32 +: 31] : 31'hx),
                      128'(din[k*32+1 +: 31]));
        end
        a_dly_sel = 1'b0;

        // Delayed MISO with compensation
        for (int t = 0; t < 3; t++) b_xfer({$urandom, $urandom});

        // Back-to-back with data_in_v held high
        a_clear();
        for (int t = 0; t < 3; t++) w[t] = rand128();
        @(posedge clk); #1;
        n = 0;
        while (!a_rdy && n < 400) begin
            @(posedge clk); #1;
            n++;
        end
        a_din = w[0];
        a_v   = 1'b1;
        for (int t = 0; t < 3; t++) begin
            n = 0;
            while (a_hs_q.size() <= t && n < 400) begin
                @(posedge clk); #1;
                n++;
            end
            if (t < 2) a_din = w[t+1];
            else       a_v = 1'b0;
        end
        a_wait_dv(3);
        repeat (3) @(posedge clk);
        check("b2b_pulses", 128'(a_dv_cnt), 128'd3);
        if (a_hs_q.size() == 3 && a_csr_q.size() >= 2) begin
            check("b2b_period0", 128'(a_hs_q[1] - a_hs_q[0]), 128'd147);
            check("b2b_period1", 128'(a_hs_q[2] - a_hs_q[1]), 128'd147);
            check("b2b_cs_off0", 128'(a_hs_q[1] - a_csr_q[0]), 128'd16);
            check("b2b_cs_off1", 128'(a_hs_q[2] - a_csr_q[1]), 128'd16);
        end else begin
            check("b2b_handshakes", 128'(a_hs_q.size()), 128'd3);
        end
        for (int t = 0; t < 3; t++)
            check("b2b_data", (a_dv_q.size() > t) ? a_dv_q[t] : 128'hx, w[t]);

        // Requests while busy are ignored
        a_clear();
        din = rand128();
        a_send(din);
        repeat (40) @(posedge clk);
        #1;
        a_din = {4{32'h12345678}};
        a_v   = 1'b1;
        @(negedge clk);
        check("busy_ready", 128'(a_rdy), 128'd0);
        @(posedge clk); #1;
        a_v = 1'b0;
        a_wait_dv(1);
        repeat (30) @(posedge clk);
        check("busy_data",       (a_dv_q.size() > 0) ? a_dv_q[0] : 128'hx, din);
        check("busy_handshakes", 128'(a_hs_q.size()), 128'd1);
        check("busy_pulses",     128'(a_dv_cnt), 128'd1);

        // Asynchronous reset in the middle of a transfer
        a_clear();
        din = rand128();
        a_send(din);
        n = 0;
        while (a_rises < 11 && n < 400) begin
            @(posedge clk);
            n++;
        end
        if (a_rises < 11) check("rst_rise_timeout", 128'(a_rises), 128'd11);
        #4;
        rst_n = 1'b0;
        #1;
        check("rst_cs",    128'(a_cs),   128'd1);
        check("rst_sclk",  128'(a_sclk), 128'd0);
        check("rst_mosi",  128'(a_mosi), 128'd0);
        check("rst_count", 128'(a_cnt),  128'd0);
        check("rst_dv",    128'(a_dv),   128'd0);
        check("rst_ready", 128'(a_rdy),  128'd1);
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
        repeat (200) @(posedge clk);
        check("rst_no_dv", 128'(a_dv_cnt), 128'd0);
        din = rand128();
        a_send(din);
        a_wait_dv(1);
        check("rst_after_data",  (a_dv_q.size() > 0) ? a_dv_q[0] : 128'hx, din);
        check("rst_after_count", 128'(a_cnt), 128'd1);

        // Odd parameters and counter wrap
        for (int t = 1; t <= 17; t++) begin
            cd = 16'($urandom);
            c_xfer(cd, t);
            check("c_data", 128'((c_dv_q.size() >= t) ? c_dv_q[t-1] : 16'hx), 128'(cd));
            if (t == 1) begin
                check("c_cs_low", 128'(c_cs_low), 128'd33);
                check("c_rises",  128'(c_rin),    128'd16);
            end
            if (t >= 15) check("c_count", 128'(c_cnt), 128'(t % 16));
        end
        check("c_sclk_period", 128'(c_bad), 128'd0);

        check("sclk_while_cs_high", 128'(a_sclk_cs_hi), 128'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/spi_master_multi.md
# spi_master_multi

Parametrised SPI master for Intan RHS2116 stimulation/recording chips, mode CPOL = 0, CPHA = 0. It drives N_CH chips in lockstep from one shared chip-select and SCLK, with one MOSI/MISO pair per chip. Compared with the two-channel master, it adds a programmable SCLK divider, a programmable CS-off time, per-transfer MISO sample-delay compensation for cable/isolator round-trip delay, and a transfer counter. It sits between the acquisition sequencer (valid/ready word interface) and the headstage pins.

## Interface

**Parameters**

- `WORD_LENGTH`, default 32: bits per transfer, MSB first. Minimum 2.
- `N_CH`, default 4: number of MOSI/MISO lanes. Minimum 1.
- `HALF_PERIOD`, default 2: clk cycles per SCLK half period. Minimum 1. Default gives 25 MHz from 100 MHz.
- `CS_HIGH_CYCLES`, default 16: clk cycles CS stays high between transfers. Minimum 1. Default gives 160 ns, above the tCSOFF of 154 ns.
- `MISO_DELAY`, default 0: clk cycles from each SCLK rising edge to the MISO sample point. Legal range 0 to 2*HALF_PERIOD-1.
- `COUNT_WIDTH`, default 16: width of `xfer_count`.

**Ports**

- `clk`, in, 1: single system clock. All logic is on the rising edge.
- `reset`, in, 1: asynchronous, active-low reset.
- `cs`, out, 1: shared chip select, active low.
- `sclk`, out, 1: shared SPI clock, registered.
- `mosi`, out, N_CH: lane k carries channel k.
- `miso`, in, N_CH: lane k.
- `data_in_v`, in, 1: request valid.
- `ready_out`, out, 1: the block can accept a request.
- `data_in`, in, N_CH*WORD_LENGTH: channel k occupies bits [k*WORD_LENGTH +: WORD_LENGTH].
- `data_out_v`, out, 1: one-cycle pulse, received words valid.
- `data_out`, out, N_CH*WORD_LENGTH: received words, same packing as `data_in`.
- `xfer_count`, out, COUNT_WIDTH: number of completed transfers, wraps.

## Operation

- **States:** IDLE, SETUP, SHIFT, CS_OFF.
- **IDLE**
  - Outputs: `ready_out`=1, `cs`=1, `sclk`=0.
  - A handshake is `data_in_v`=1 and `ready_out`=1 at a clk edge.
  - On a handshake: latch all N_CH words into the TX shift registers, drop `ready_out`, go to SETUP.
- **SETUP**
  - `cs`=0, `sclk`=0.
  - `mosi[k]` = MSB of word k.
  - Lasts HALF_PERIOD cycles, then go to SHIFT.
- **SHIFT**
  - Each bit is one high phase then one low phase, each HALF_PERIOD cycles long.
  - `mosi` changes only on SCLK falling edges, to the next bit. After the last falling edge `mosi` holds the LSB.
  - MISO sampling:
    - Each rising edge arms a sample strobe that fires MISO_DELAY cycles later.
    - When the strobe fires, every lane shifts `miso[k]` into RX register k, LSB in.
    - Exactly WORD_LENGTH samples are taken per lane.
  - Leave SHIFT after the low phase of bit WORD_LENGTH-1.
- **CS_OFF**
  - `cs`=1, `sclk`=0.
  - On entry: copy the RX registers to `data_out`, pulse `data_out_v` for one cycle, increment `xfer_count`.
  - After CS_HIGH_CYCLES cycles, go to IDLE.
- **Ignored inputs:** `data_in_v` outside IDLE has no effect. The word on `data_in` is not captured.
- **Held outputs:** `data_out` keeps its value until the next completed transfer.
- **Counter:** `xfer_count` increments modulo 2^COUNT_WIDTH, so all-ones wraps to 0.
- **Reset**
  - Asserted at any time, including mid-transfer: asynchronously force IDLE, `cs`=1, `sclk`=0, `mosi`=0, `data_out_v`=0, `data_out`=0, `xfer_count`=0, `ready_out`=1.
  - An aborted transfer produces no `data_out_v`.

## Timing

Let H = HALF_PERIOD, W = WORD_LENGTH, and let the handshake happen at edge T.

- `cs` falls at T+1.
- First SCLK rise at T+1+H.
- Rise i (0-based) at T+1+H+2iH; fall i at T+1+2H+2iH.
- Sample i at T+1+H+2iH+MISO_DELAY, which is always before fall i+1.
- `cs` rises, and `data_out_v` is high, at T+1+H+2WH.
- `ready_out` returns at T+1+H+2WH+CS_HIGH_CYCLES.
- Minimum request period is 1+H+2WH+CS_HIGH_CYCLES. With defaults this is 147 cycles.
- With `data_in_v` held high, the next handshake occurs in the first IDLE cycle.
- SCLK duty cycle is exactly 50%. No SCLK edge occurs while `cs`=1.

## Test plan

1. **Single transfer, loopback.** Defaults; `miso`=`mosi` per lane; send ch0..3 = 0xA5A50001, 0x80000000, 0xFFFFFFFF, 0x00000000. Required: `cs` low for exactly 130 cycles, 32 rising edges, `data_out` = `data_in`, one `data_out_v` pulse at T+131, `xfer_count`=1.
2. **Delay compensation.** Model returns `mosi` delayed by 3 clk; MISO_DELAY=3, H=2. Required: `data_out` = `data_in`. With MISO_DELAY=0, the same model makes lane data arrive a bit late and the bench checks the expected misaligned value.
3. **Back-to-back.** `data_in_v` held high for 3 transfers. Required: `cs` high exactly 16 cycles between transfers, handshakes 147 cycles apart, three `data_out_v` pulses.
4. **Busy requests ignored.** Pulse `data_in_v` with 0x12345678 during SHIFT. Required: no capture, the current transfer is unchanged, `ready_out` stays 0.
5. **Reset mid-transfer.** Assert `reset`=0 after bit 10, asynchronously between clk edges. Required: immediately `cs`=1, `sclk`=0, `mosi`=0, `xfer_count`=0, no `data_out_v`; after release `ready_out`=1 and a new transfer completes correctly.
6. **Counter wrap and odd parameters.** COUNT_WIDTH=4, H=1, W=16, N_CH=1; run 17 transfers. Required: `xfer_count` goes 15 → 0 → 1; SCLK period is 2 cycles; `cs` is low for 33 cycles per transfer.
